// File: rtl/apb_ram_ws.sv
// APB slave scratch RAM with byte strobes, alignment/range/read-only error checks and a saturating error count.
// Latency: pready in setup+2+WAIT_STATES; the master stalls via pready, and dropping psel mid-access aborts with no side effects.
module apb_ram_ws #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int RO_BASE     = DEPTH
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [7:0]          err_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               mem_we;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0]  word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic               misaligned;
    logic               idx_oor;
    logic               ro_hit;
    logic               xfer_err;

    // Byte address to word index; the offset mask is zero for 8-bit buses, so alignment never fails there.
    assign word_idx   = paddr >> OFF_W;
    assign mem_idx    = word_idx[IDX_W-1:0];
    assign misaligned = (paddr & ADDR_W'(BYTES - 1)) != '0;
    assign idx_oor    = word_idx >= ADDR_W'(DEPTH);
    assign ro_hit     = word_idx >= ADDR_W'(RO_BASE);
    assign xfer_err   = idx_oor | misaligned | (pwrite & ro_hit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d  = RESP;
                        pready_d = 1'b1;
                        if (xfer_err) begin
                            pslverr_d = 1'b1;
                            if (!pwrite) begin
                                prdata_d = '0;
                            end
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end else if (pwrite) begin
                            mem_we = 1'b1;
                        end else begin
                            prdata_d = mem_q[mem_idx];
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Write commits on the edge into RESP, so a following read of the same word sees the new data.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pstrb[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_ram_ws.sv
// Bench for apb_ram_ws: two instances (no wait states with read-only top words; three wait states),
// directed cases plus random traffic checked against a word-array model of the RAM.
module tb_apb_ram_ws;

    localparam int WS0 = 0;
    localparam int WS1 = 3;
    localparam int RO0 = 60;
    localparam int RO1 = 64;

    logic        pclk;
    logic        preset    [2];
    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] paddr     [2];
    logic [31:0] pwdata    [2];
    logic [3:0]  pstrb     [2];
    logic [31:0] prdata_o  [2];
    logic        pready_o  [2];
    logic        pslverr_o [2];
    logic [7:0]  err_cnt_o [2];

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [2][64];
    logic [31:0] ref_prd [2];
    int          ref_err [2];

    apb_ram_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(WS0), .RO_BASE(RO0)) u_dut0 (
        .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .prdata(prdata_o[0]), .pready(pready_o[0]), .pslverr(pslverr_o[0]), .err_cnt(err_cnt_o[0])
    );

    apb_ram_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(WS1), .RO_BASE(RO1)) u_dut1 (
        .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .prdata(prdata_o[1]), .pready(pready_o[1]), .pslverr(pslverr_o[1]), .err_cnt(err_cnt_o[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear(input int k);
        for (int i = 0; i < 64; i++) ref_mem[k][i] = '0;
        ref_prd[k] = '0;
        ref_err[k] = 0;
    endtask

    task automatic do_reset(input int k);
        @(posedge pclk); #1;
        preset[k]  = 1'b1;
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        preset[k] = 1'b0;
        model_clear(k);
    endtask

    // Full APB transfer; the model decides error, data and latency from the address rules alone.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st);
        int          n;
        bit          seen;
        bit          e;
        logic [31:0] idx;
        int          ro;
        int          ws;
        ro  = (k == 0) ? RO0 : RO1;
        ws  = (k == 0) ? WS0 : WS1;
        idx = addr >> 2;
        e   = (idx >= 32'd64) || (addr[1:0] != 2'b00) || (wr && idx >= 32'(ro));
        @(posedge pclk); #1;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = wd; pstrb[k] = st;
        @(posedge pclk); #1;
        penable[k] = 1'b1;
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (pready_o[k]) seen = 1'b1;
            else begin
                @(posedge pclk); #1;
                n++;
            end
        end
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        if (!seen) begin
            chk("pready_timeout", 32'd0, 32'd1);
        end else begin
            if (e) begin
                ref_err[k] = (ref_err[k] >= 255) ? 255 : ref_err[k] + 1;
                if (!wr) ref_prd[k] = '0;
            end else if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) ref_mem[k][idx[5:0]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                ref_prd[k] = ref_mem[k][idx[5:0]];
            end
            chk("latency", 32'(n), 32'(2 + ws));
            chk("pslverr", 32'(pslverr_o[k]), 32'(e));
            chk(wr ? "prdata_hold" : "rdata", prdata_o[k], ref_prd[k]);
            chk("err_cnt", 32'(err_cnt_o[k]), 32'(ref_err[k]));
        end
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        for (int i = 0; i < 2; i++) begin
            preset[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
        end
        do_reset(0);
        do_reset(1);
        for (int i = 0; i < 2; i++) begin
            chk("rst_prdata", prdata_o[i], 32'd0);
            chk("rst_pready", 32'(pready_o[i]), 32'd0);
            chk("rst_pslverr", 32'(pslverr_o[i]), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt_o[i]), 32'd0);
        end

        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0);
        chk("rd5_after_reset", prdata_o[0], 32'd0);

        xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'hF);
        xfer(0, 1'b1, 32'h08, 32'h11223344, 4'b0101);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);
        chk("strb_merge", prdata_o[0], 32'hAA22CC44);
        xfer(0, 1'b1, 32'h08, 32'h99999999, 4'h0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);
        chk("strb_zero_noop", prdata_o[0], 32'hAA22CC44);

        xfer(0, 1'b1, 32'h102, 32'h12345678, 4'hF);
        xfer(0, 1'b0, 32'h100, 32'h0, 4'h0);
        chk("oor_rd_zero", prdata_o[0], 32'd0);
        xfer(0, 1'b1, 32'hF8, 32'hCAFEF00D, 4'hF);
        chk("ro_wr_err", 32'(pslverr_o[0]), 32'd1);
        xfer(0, 1'b0, 32'hF8, 32'h0, 4'h0);
        chk("ro_rd_unchanged", prdata_o[0], 32'd0);
        chk("err_cnt_three", 32'(err_cnt_o[0]), 32'd3);

        xfer(1, 1'b1, 32'h20, 32'h5A5A1234, 4'hF);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(posedge pclk); #1;
        chk("ws_pready_pulse", 32'(pready_o[1]), 32'd0);

        // Abort: psel dropped in the access phase of a write.
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h0C; pwdata[0] = 32'hDEAD0001; pstrb[0] = 4'hF;
        @(posedge pclk); #1;
        psel[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_pready", 32'(pready_o[0]), 32'd0);
            @(posedge pclk); #1;
        end
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0);

        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 69)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) a = a | 32'h1000_0000;
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 300; i++) xfer(0, 1'b0, 32'h101, 32'h0, 4'h0);
        chk("err_cnt_sat", 32'(err_cnt_o[0]), 32'd255);

        // Reset during the access phase of a write to word 0.
        xfer(0, 1'b1, 32'h00, 32'h01020304, 4'hF);
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h00; pwdata[0] = 32'hDEADBEEF; pstrb[0] = 4'hF;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        preset[0]  = 1'b1;
        @(posedge pclk); #1;
        preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        model_clear(0);
        chk("midrst_pready", 32'(pready_o[0]), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt_o[0]), 32'd0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0);
        chk("midrst_mem0", prdata_o[0], 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
